baud_tick_generator: RTL and testbench

- Parametrised successor to the fixed x16 UART baud generator.
- Produces registered single-cycle strobes from a runtime divisor:
  - an oversample tick,
  - a mid-bit sample tick,
  - a full-bit baud tick.
- Adds a configurable oversampling ratio, glitch-free divisor updates, enable/restart control for RX start-bit alignment, and an optional fractional divisor.
- Sits between the CSR block and the TX/RX engines; one instance per direction.

---
 rtl/baud_tick_generator.sv | 135 +++++++++++++
 tb/tb_baud_tick_generator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_tick_generator.sv
// Baud tick generator: runtime integer divisor, configurable oversampling ratio,
// glitch-free divisor updates and enable/restart control for RX start-bit alignment.
// Optional fractional divisor enabled by defining BAUD_GEN_FRAC_DIVISOR_EN.
module baud_tick_generator #(
    parameter int unsigned DVSR_WIDTH = 16,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FRAC_WIDTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          enable_i,
    input  logic                          restart_i,
    input  logic [DVSR_WIDTH-1:0]         divisor_i,
    input  logic [FRAC_WIDTH-1:0]         divisor_frac_i,
    output logic                          ov_tick_o,
    output logic                          mid_tick_o,
    output logic                          baud_tick_o,
    output logic [$clog2(OVERSAMPLE)-1:0] os_count_o
);

    localparam int unsigned OsW  = $clog2(OVERSAMPLE);
    // One spare bit so a fractionally stretched period can reach div_q+1.
    localparam int unsigned PreW = DVSR_WIDTH + 1;
    localparam logic [OsW-1:0] OsLast   = OsW'(OVERSAMPLE - 1);
    localparam logic [OsW-1:0] OsMidPre = OsW'(OVERSAMPLE / 2 - 1);

    if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
        $error("OVERSAMPLE must be even and >= 4");
    end

    logic [DVSR_WIDTH-1:0] div_q;
    logic [PreW-1:0]       pre_cnt_q, pre_cnt_d;
    logic [OsW-1:0]        os_cnt_q, os_cnt_d;
    logic                  ov_q, ov_d;
    logic                  mid_q, mid_d;
    logic                  baud_q, baud_d;
    logic [PreW-1:0]       period_end;
    logic                  ov_event;
    logic                  clear;
    logic                  load_shadow;

    // Restart wins over enable and over a coincident wrap.
    assign clear       = restart_i || !enable_i;
    assign ov_event    = !clear && (pre_cnt_q == period_end);
    assign load_shadow = clear || ov_event;

`ifdef BAUD_GEN_FRAC_DIVISOR_EN
    logic [FRAC_WIDTH-1:0] frac_q;
    logic [FRAC_WIDTH-1:0] acc_q, acc_d;
    logic                  ext_q, ext_d;
    logic [FRAC_WIDTH:0]   acc_sum;

    assign acc_sum    = {1'b0, acc_q} + {1'b0, frac_q};
    assign period_end = {1'b0, div_q} + PreW'(ext_q);

    // Fractional accumulator: a carry stretches the following period by one clock.
    always_comb begin
        acc_d = acc_q;
        ext_d = ext_q;
        if (clear) begin
            acc_d = '0;
            ext_d = 1'b0;
        end else if (ov_event) begin
            acc_d = acc_sum[FRAC_WIDTH-1:0];
            ext_d = acc_sum[FRAC_WIDTH];
        end
    end

    // Fractional shadow and accumulator state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frac_q <= '0;
            acc_q  <= '0;
            ext_q  <= 1'b0;
        end else begin
            if (load_shadow) begin
                frac_q <= divisor_frac_i;
            end
            acc_q <= acc_d;
            ext_q <= ext_d;
        end
    end
`else
    logic unused_frac;

    assign unused_frac = ^divisor_frac_i;
    assign period_end  = {1'b0, div_q};
`endif

    // Prescaler and oversample counter next state plus strobe decode.
    always_comb begin
        pre_cnt_d = pre_cnt_q + PreW'(1);
        os_cnt_d  = os_cnt_q;
        ov_d      = 1'b0;
        mid_d     = 1'b0;
        baud_d    = 1'b0;
        if (clear) begin
            pre_cnt_d = '0;
            os_cnt_d  = '0;
        end else if (ov_event) begin
            pre_cnt_d = '0;
            os_cnt_d  = (os_cnt_q == OsLast) ? '0 : os_cnt_q + OsW'(1);
            ov_d      = 1'b1;
            mid_d     = (os_cnt_q == OsMidPre);
            baud_d    = (os_cnt_q == OsLast);
        end
    end

    // Counter, shadow divisor and registered strobe state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q     <= '0;
            pre_cnt_q <= '0;
            os_cnt_q  <= '0;
            ov_q      <= 1'b0;
            mid_q     <= 1'b0;
            baud_q    <= 1'b0;
        end else begin
            if (load_shadow) begin
                div_q <= divisor_i;
            end
            pre_cnt_q <= pre_cnt_d;
            os_cnt_q  <= os_cnt_d;
            ov_q      <= ov_d;
            mid_q     <= mid_d;
            baud_q    <= baud_d;
        end
    end

    assign ov_tick_o   = ov_q;
    assign mid_tick_o  = mid_q;
    assign baud_tick_o = baud_q;
    assign os_count_o  = os_cnt_q;

endmodule

// File: tb/tb_baud_tick_generator.sv
// Scoreboard bench for baud_tick_generator: stimulus pushes expected strobes,
// a negedge monitor pops and compares whenever any strobe is presented.
module tb_baud_tick_generator;

    localparam int OV = 16;
    localparam int DW = 16;
    localparam int FW = 4;
`ifdef BAUD_GEN_FRAC_DIVISOR_EN
    localparam bit FracEn = 1'b1;
`else
    localparam bit FracEn = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          enable_i;
    logic          restart_i;
    logic [DW-1:0] divisor_i;
    logic [FW-1:0] divisor_frac_i;
    logic          ov_tick_o;
    logic          mid_tick_o;
    logic          baud_tick_o;
    logic [3:0]    os_count_o;

    typedef struct {
        int cyc;
        bit mid;
        bit baud;
        int os;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    baud_tick_generator #(
        .DVSR_WIDTH(DW),
        .OVERSAMPLE(OV),
        .FRAC_WIDTH(FW)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .enable_i      (enable_i),
        .restart_i     (restart_i),
        .divisor_i     (divisor_i),
        .divisor_frac_i(divisor_frac_i),
        .ov_tick_o     (ov_tick_o),
        .mid_tick_o    (mid_tick_o),
        .baud_tick_o   (baud_tick_o),
        .os_count_o    (os_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Edge counter: a strobe caused by edge N is seen at the negedge where cyc == N.
    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: every presented strobe must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (ov_tick_o || mid_tick_o || baud_tick_o) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: cycle %0d ov=%0b mid=%0b baud=%0b os=%0d, required no strobe",
                         cyc, ov_tick_o, mid_tick_o, baud_tick_o, os_count_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc != mon_e.cyc || ov_tick_o !== 1'b1 || mid_tick_o !== mon_e.mid ||
                    baud_tick_o !== mon_e.baud || int'(os_count_o) != mon_e.os) begin
                    n_fail++;
                    $display("FAIL strobe: got cycle %0d ov=%0b mid=%0b baud=%0b os=%0d, required cycle %0d ov=1 mid=%0b baud=%0b os=%0d",
                             cyc, ov_tick_o, mid_tick_o, baud_tick_o, os_count_o,
                             mon_e.cyc, mon_e.mid, mon_e.baud, mon_e.os);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_one(input int c, input int os, input bit mid, input bit baud);
        exp_t e;
        e.cyc  = c;
        e.os   = os;
        e.mid  = mid;
        e.baud = baud;
        exp_q.push_back(e);
    endtask

    // Expected ticks after a clear at edge t0; carry on an ov event stretches the next period.
    task automatic push_ticks(input int t0, input int d, input int f, input int n, output int last);
        int t;
        int acc;
        int ext;
        int sum;
        t   = t0;
        acc = 0;
        ext = 0;
        for (int k = 1; k <= n; k++) begin
            t = t + d + 1 + ext;
            push_one(t, k % OV, (k % OV) == OV / 2, (k % OV) == 0);
            if (FracEn) begin
                sum = acc + f;
                ext = (sum >= (1 << FW)) ? 1 : 0;
                acc = sum % (1 << FW);
            end
        end
        last = t;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic disable_and_check(input string name);
        enable_i = 1'b0;
        @(posedge clk_i);
        #1;
        check({name, "_off_os"}, os_count_o, 0);
        check({name, "_off_ov"}, ov_tick_o, 0);
    endtask

    // Restart with divisor d / fraction f, run n ticks, then disable.
    task automatic run_seg(input string name, input int d, input int f, input int n);
        int t0;
        int last;
        @(posedge clk_i);
        #1;
        divisor_i      = DW'(d);
        divisor_frac_i = FW'(f);
        enable_i       = 1'b1;
        restart_i      = 1'b1;
        t0             = cyc + 1;
        push_ticks(t0, d, f, n, last);
        @(posedge clk_i);
        #1;
        restart_i = 1'b0;
        wait_until(last);
        disable_and_check(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

    initial begin
        int t0;
        int t1;
        int last;
        rst_n_i        = 1'b0;
        enable_i       = 1'b0;
        restart_i      = 1'b0;
        divisor_i      = DW'(3);
        divisor_frac_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_ov", ov_tick_o, 0);
        check("reset_mid", mid_tick_o, 0);
        check("reset_baud", baud_tick_o, 0);
        check("reset_os", os_count_o, 0);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // D=3: ov every 4, mid at +32, baud at +64 and +128.
        run_seg("d3", 3, 0, 32);
        // D=0: ov every cycle, baud every 16.
        run_seg("d0", 0, 0, 32);

        // Divisor 3 -> 7 two cycles into a period: that period stays 4.
        @(posedge clk_i);
        #1;
        divisor_i = DW'(3);
        enable_i  = 1'b1;
        restart_i = 1'b1;
        t0        = cyc + 1;
        push_one(t0 + 4, 1, 1'b0, 1'b0);
        push_one(t0 + 8, 2, 1'b0, 1'b0);
        push_one(t0 + 16, 3, 1'b0, 1'b0);
        push_one(t0 + 24, 4, 1'b0, 1'b0);
        push_one(t0 + 32, 5, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;
        restart_i = 1'b0;
        wait_until(t0 + 6);
        divisor_i = DW'(7);
        wait_until(t0 + 32);
        disable_and_check("dchg");

        // Restart on the wrap cycle with os=15: event discarded, phase restarts.
        @(posedge clk_i);
        #1;
        divisor_i = DW'(3);
        enable_i  = 1'b1;
        restart_i = 1'b1;
        t0        = cyc + 1;
        push_ticks(t0, 3, 0, 15, last);
        @(posedge clk_i);
        #1;
        restart_i = 1'b0;
        wait_until(t0 + 63);
        check("pre_wrap_os", os_count_o, 15);
        restart_i = 1'b1;
        @(posedge clk_i);
        #1;
        restart_i = 1'b0;
        t1        = cyc;
        #3;
        check("restart_wrap_ov", ov_tick_o, 0);
        check("restart_wrap_baud", baud_tick_o, 0);
        check("restart_wrap_os", os_count_o, 0);
        push_ticks(t1, 3, 0, 2, last);
        wait_until(last);
        disable_and_check("rwrap");

        // Fractional divisor D=3 F=8 (period exactly 4 when the feature is absent).
        run_seg("frac", 3, 8, 17);

        // Asynchronous reset while strobes are active.
        @(posedge clk_i);
        #1;
        divisor_i      = DW'(0);
        divisor_frac_i = '0;
        enable_i       = 1'b1;
        restart_i      = 1'b1;
        t0             = cyc + 1;
        push_ticks(t0, 0, 0, 19, last);
        @(posedge clk_i);
        #1;
        restart_i = 1'b0;
        wait_until(t0 + 20);
        check("pre_reset_ov", ov_tick_o, 1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async_reset_ov", ov_tick_o, 0);
        check("async_reset_mid", mid_tick_o, 0);
        check("async_reset_baud", baud_tick_o, 0);
        check("async_reset_os", os_count_o, 0);
        enable_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_n_i   = 1'b1;
        divisor_i = DW'(3);
        @(posedge clk_i);
        #1;
        enable_i = 1'b1;
        t0       = cyc;
        push_ticks(t0, 3, 0, 3, last);
        wait_until(last);
        disable_and_check("post_reset");

        repeat (4) @(posedge clk_i);
        #1;
        check("scoreboard_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
